// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings (common with alu_control_unit),
// default datapath width, and the execute-unit FSM / shifter type enums.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_e;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

  function automatic shift_e shift_type_of(input logic [3:0] code);
    case (code)
      ALU_SRL: return SH_SRL;
      ALU_SRA: return SH_SRA;
      default: return SH_SLL;
    endcase
  endfunction

endpackage

// File: rtl/alu_multicycle_exec_if.sv
// Request/response bundle between the decode stage (master) and the
// multicycle execute unit (slave).
interface alu_multicycle_exec_if
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, alu_control, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_control, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, zero
  );

endinterface

// File: rtl/alu_multicycle_exec_serial_shifter.sv
// One-bit-per-cycle shifter: a work register plus a down-counter of
// remaining steps. data_next is the work value after the current step;
// done flags the step that brings the counter to zero.
module serial_shifter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  shift_e                   shift_type,
  input  logic [$clog2(XLEN)-1:0]  shamt,
  input  logic [XLEN-1:0]          data_in,
  output logic [XLEN-1:0]          data_next,
  output logic                     done
);

  localparam int SHW = $clog2(XLEN);

  shift_e          type_q;
  logic [XLEN-1:0] work_q;
  logic [SHW-1:0]  count_q;

  // Single-step shift of the work register according to the latched type.
  always_comb begin
    data_next = work_q;
    case (type_q)
      SH_SLL:  data_next = {work_q[XLEN-2:0], 1'b0};
      SH_SRL:  data_next = {1'b0, work_q[XLEN-1:1]};
      SH_SRA:  data_next = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: data_next = work_q;
    endcase
  end

  assign done = (count_q == SHW'(1));

  // Load on request, then step once per cycle until the count runs out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q  <= '0;
      count_q <= '0;
      type_q  <= SH_SLL;
    end else if (load) begin
      work_q  <= data_in;
      count_q <= shamt;
      type_q  <= shift_type;
    end else if (count_q != '0) begin
      work_q  <= data_next;
      count_q <= count_q - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle_exec.sv
// Iterative execute unit: single-cycle logic/arith/compare ops, serial
// shifts, valid/ready on both sides. IDLE is re-entered after every op.
module alu_multicycle_exec
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_multicycle_exec_if.slave bus
);

  localparam int SHW = $clog2(XLEN);

  state_e          state;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_y;
  logic            start_shift;
  logic [XLEN-1:0] shift_next;
  logic            shift_done;

  assign op_a  = bus.operand_a;
  assign op_b  = bus.operand_b;
  assign shamt = op_b[SHW-1:0];

  assign bus.in_ready  = (state == ST_IDLE) && rst_n;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

  // A shift with nonzero amount goes to the serial shifter; everything else
  // (including a zero-amount shift) completes through the inline mux.
  assign start_shift = (state == ST_IDLE) && bus.in_valid &&
                       is_shift(bus.alu_control) && (shamt != '0);

  // Single-cycle operation mux; illegal codes produce zero.
  always_comb begin
    alu_y = '0;
    case (bus.alu_control)
      ALU_AND:  alu_y = op_a & op_b;
      ALU_OR:   alu_y = op_a | op_b;
      ALU_XOR:  alu_y = op_a ^ op_b;
      ALU_ADD:  alu_y = op_a + op_b;
      ALU_SUB:  alu_y = op_a - op_b;
      ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_y = op_a;
      default:  alu_y = '0;
    endcase
  end

  serial_shifter #(.XLEN(XLEN)) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (start_shift),
    .shift_type (shift_type_of(bus.alu_control)),
    .shamt      (shamt),
    .data_in    (op_a),
    .data_next  (shift_next),
    .done       (shift_done)
  );

  // Control FSM with registered result, zero flag and out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            if (start_shift) begin
              state <= ST_SHIFT;
            end else begin
              result_q    <= alu_y;
              zero_q      <= (alu_y == '0);
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          if (shift_done) begin
            result_q    <= shift_next;
            zero_q      <= (shift_next == '0);
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle_exec.sv
// Bench for alu_multicycle_exec: a cycle-level reference model plus a
// per-cycle compare process, and directed vectors with literal expectations.
module tb_alu_multicycle_exec;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   tb_live = 1'b0;

  alu_multicycle_exec_if bus ();

  alu_multicycle_exec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of each operation, straight from the opcode table.
  function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
    int unsigned sh;
    sh = int'(b[4:0]);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a << sh;
      4'b0100: return a >> sh;
      4'b0101: return $unsigned($signed(a) >>> sh);
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return (a < b) ? 32'd1 : 32'd0;
      4'b1001: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] c, input logic [31:0] b);
    if ((c == 4'b0011 || c == 4'b0100 || c == 4'b0101) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Model state: whether the unit is free, whether a result is on offer,
  // cycles left until it appears, and whether result/zero are defined now.
  bit          m_idle = 1'b1;
  bit          m_valid = 1'b0;
  bit          m_known = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_res = '0;
  logic        m_zero = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_idle = 1'b1; m_valid = 1'b0; m_known = 1'b1;
      m_wait = 0; m_res = '0; m_zero = 1'b0;
    end else if (m_valid) begin
      if (bus.out_ready) begin
        m_valid = 1'b0; m_idle = 1'b1; m_known = 1'b0;
      end
    end else if (m_idle) begin
      if (bus.in_valid) begin
        m_idle = 1'b0; m_known = 1'b0;
        m_pend = ref_result(bus.alu_control, bus.operand_a, bus.operand_b);
        m_wait = ref_latency(bus.alu_control, bus.operand_b) - 1;
        if (m_wait == 0) begin
          m_valid = 1'b1; m_known = 1'b1; m_res = m_pend; m_zero = (m_pend == 0);
        end
      end
    end else begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1'b1; m_known = 1'b1; m_res = m_pend; m_zero = (m_pend == 0);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (tb_live) begin
      check("cmp in_ready", {31'd0, bus.in_ready}, {31'd0, (rst_n && m_idle)});
      check("cmp out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      if (m_known) begin
        check("cmp result", bus.result, m_res);
        check("cmp zero", {31'd0, bus.zero}, {31'd0, m_zero});
      end
    end
  end

  typedef struct {
    string       name;
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
    int          hold;
    bit          early;
    bit          noise;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string n, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] r, input logic z,
                     input int lat, input int hold, input bit early, input bit noise);
    vec_t v;
    v.name = n; v.code = c; v.a = a; v.b = b; v.res = r; v.z = z;
    v.lat = lat; v.hold = hold; v.early = early; v.noise = noise;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input vec_t v);
    int cyc;
    bus.in_valid    = 1'b1;
    bus.alu_control = v.code;
    bus.operand_a   = v.a;
    bus.operand_b   = v.b;
    bus.out_ready   = 1'b0;
    tick();
    bus.in_valid    = v.noise;
    bus.alu_control = 4'b0010;
    bus.operand_a   = $urandom;
    bus.operand_b   = $urandom;
    if (v.early) bus.out_ready = 1'b1;
    cyc = 1;
    while (!bus.out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check({v.name, " latency"}, cyc, v.lat);
    check({v.name, " result"}, bus.result, v.res);
    check({v.name, " zero"}, {31'd0, bus.zero}, {31'd0, v.z});
    for (int i = 0; i < v.hold; i++) begin
      tick();
      check({v.name, " hold out_valid"}, {31'd0, bus.out_valid}, 32'd1);
      check({v.name, " hold result"}, bus.result, v.res);
      check({v.name, " hold zero"}, {31'd0, bus.zero}, {31'd0, v.z});
      check({v.name, " hold in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({v.name, " in_ready after take"}, {31'd0, bus.in_ready}, 32'd1);
    check({v.name, " out_valid after take"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.alu_control = '0; bus.operand_a = '0;
    bus.operand_b = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tb_live = 1'b1;
    tick();
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset zero", {31'd0, bus.zero}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("release in_ready", {31'd0, bus.in_ready}, 32'd1);

    //   name            code     a             b             result        z  lat hold early noise
    add("add 5+7",       4'b0010, 32'd5,        32'd7,        32'h0000000C, 0, 1,  0,  0, 0);
    add("sub 3-5",       4'b0110, 32'd3,        32'd5,        32'hFFFFFFFE, 0, 1,  0,  0, 0);
    add("slt -1<1",      4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        0, 1,  0,  0, 0);
    add("sltu max<1",    4'b1000, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 1,  0,  0, 0);
    add("sra by 4",      4'b0101, 32'h80000000, 32'd4,        32'hF8000000, 0, 5,  0,  0, 0);
    add("srl by 4",      4'b0100, 32'h80000000, 32'd4,        32'h08000000, 0, 5,  0,  1, 0);
    add("sll shamt 0",   4'b0011, 32'd1,        32'hFFFFFFE0, 32'd1,        0, 1,  0,  0, 0);
    add("sll by 31",     4'b0011, 32'd1,        32'd31,       32'h80000000, 0, 32, 0,  0, 1);
    add("and",           4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 1,  0,  0, 0);
    add("or",            4'b0001, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 0, 1,  0,  0, 0);
    add("xor self",      4'b1001, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd0,        1, 1,  0,  0, 0);
    add("add wrap",      4'b0010, 32'hFFFFFFFF, 32'd2,        32'd1,        0, 1,  0,  0, 0);
    add("add to zero",   4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1, 1,  0,  0, 0);
    add("sra hi bits",   4'b0101, 32'h7FFFFFF0, 32'h00000024, 32'h07FFFFFF, 0, 5,  0,  0, 0);
    add("slt neg",       4'b0111, 32'h80000000, 32'd1,        32'd1,        0, 1,  0,  0, 0);
    add("sltu big",      4'b1000, 32'd1,        32'h80000000, 32'd1,        0, 1,  0,  0, 0);
    add("illegal 1111",  4'b1111, 32'd123,      32'd456,      32'd0,        1, 1,  0,  0, 0);
    add("illegal 1010",  4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1, 1,  0,  0, 0);
    add("backpressure",  4'b0110, 32'd10,       32'd3,        32'd7,        0, 1,  10, 0, 0);
    add("srl bp",        4'b0100, 32'hFFFFFFFF, 32'd28,       32'h0000000F, 0, 29, 3,  0, 0);

    foreach (vecs[i]) do_op(vecs[i]);

    // Reset in the middle of a long shift.
    bus.in_valid = 1'b1; bus.alu_control = 4'b0100;
    bus.operand_a = 32'hFFFFFFFF; bus.operand_b = 32'd20;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check("midshift rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midshift rst result", bus.result, 32'd0);
    check("midshift rst zero", {31'd0, bus.zero}, 32'd0);
    check("midshift rst in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("midshift release in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midshift release out_valid", {31'd0, bus.out_valid}, 32'd0);

    begin
      vec_t v;
      v.name = "after reset sll"; v.code = 4'b0011; v.a = 32'h00000003; v.b = 32'd2;
      v.res = 32'h0000000C; v.z = 1'b0; v.lat = 3; v.hold = 0; v.early = 1'b0; v.noise = 1'b0;
      do_op(v);
    end

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
